ram_arbiter: RTL and testbench

//  Two-requester round-robin arbiter in front of the single-port 64-bit data RAM
//  (16-bit address, combinational read, posedge write).

---
 rtl/ram_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM. Each accepted request gets one access cycle.
// Ties are round-robin by default; define RAM_ARB_FIXED_PRIO_EN to make port 0 always win.
module ram_arbiter #(
  parameter int ADR_W  = 16,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADR_W-1:0]  adr0,
  input  logic [ADR_W-1:0]  adr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADR_W-1:0]  ram_adr,
  output logic [DATA_W-1:0] ram_writeData,
  output logic              ram_writeEn,
  input  logic [DATA_W-1:0] ram_readData
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q;
  logic                owner_q;
  logic                cur_we_q;
  logic                gnt0_q, gnt1_q;
  logic                rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic [ADR_W-1:0]    ram_adr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                ram_we_q;

  logic                win_d;
  logic                sel_we_d;
  logic [ADR_W-1:0]    sel_adr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    win_d = ~req0;
  end
`else
  logic last_q;

  always_comb begin
    win_d = ~req0;
    if (req0 && req1) win_d = ~last_q;
  end
`endif

  always_comb begin
    sel_we_d    = win_d ? we1    : we0;
    sel_adr_d   = win_d ? adr1   : adr0;
    sel_wdata_d = win_d ? wdata1 : wdata0;
  end

  // The registered RAM address/data double as the latched request (cur_adr/cur_wdata);
  // only we and owner need their own copies to finish the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cur_we_q    <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ram_adr_q   <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          gnt0_q    <= 1'b0;
          gnt1_q    <= 1'b0;
          rvalid0_q <= 1'b0;
          rvalid1_q <= 1'b0;
          ram_we_q  <= 1'b0;
          if (req0 || req1) begin
            state_q     <= ACCESS;
            owner_q     <= win_d;
            cur_we_q    <= sel_we_d;
            ram_adr_q   <= sel_adr_d;
            ram_wdata_q <= sel_wdata_d;
            ram_we_q    <= sel_we_d;
            gnt0_q      <= ~win_d;
            gnt1_q      <= win_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_q      <= win_d;
`endif
          end
        end
        ACCESS: begin
          state_q  <= IDLE;
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          ram_we_q <= 1'b0;
          if (!cur_we_q) begin
            if (owner_q) begin
              rdata1_q  <= ram_readData;
              rvalid1_q <= 1'b1;
            end else begin
              rdata0_q  <= ram_readData;
              rvalid0_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0          = gnt0_q;
  assign gnt1          = gnt1_q;
  assign rvalid0       = rvalid0_q;
  assign rvalid1       = rvalid1_q;
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;
  assign ram_adr       = ram_adr_q;
  assign ram_writeData = ram_wdata_q;
  assign ram_writeEn   = ram_we_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboarded bench for ram_arbiter: expected read responses are queued when requests
// are driven and matched against rvalid pulses by a negedge monitor.
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [15:0] adr0, adr1;
  logic [63:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [63:0] rdata0, rdata1;
  logic [15:0] ram_adr;
  logic [63:0] ram_writeData;
  logic        ram_writeEn;
  logic [63:0] ram_readData;

  logic [63:0] mem [0:255];

  typedef struct {
    bit          port;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_tests;
  int n_fail;

  ram_arbiter #(.ADR_W(16), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_adr(ram_adr), .ram_writeData(ram_writeData), .ram_writeEn(ram_writeEn),
    .ram_readData(ram_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, posedge write, 256 words aliased over the address space
  assign ram_readData = mem[ram_adr[7:0]];
  always @(posedge clk) if (ram_writeEn) mem[ram_adr[7:0]] <= ram_writeData;

  always @(negedge clk) begin
    if (rst_n && (rvalid0 || rvalid1)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: rvalid0=%0b rvalid1=%0b with no read outstanding", rvalid0, rvalid1);
      end else begin
        exp_t e;
        logic [63:0] got;
        e = exp_q.pop_front();
        got = e.port ? rdata1 : rdata0;
        if ((rvalid0 && rvalid1) || (rvalid1 !== e.port) || (got !== e.data)) begin
          n_fail++;
          $display("FAIL sb_response: got rvalid0=%0b rvalid1=%0b data=%h, expected port %0d data=%h",
                   rvalid0, rvalid1, got, e.port, e.data);
        end
      end
    end
    if (rst_n && ((gnt0 && gnt1) || (gnt0 && rvalid0) || (gnt1 && rvalid1))) begin
      n_tests++;
      n_fail++;
      $display("FAIL illegal_overlap: gnt0=%0b gnt1=%0b rvalid0=%0b rvalid1=%0b", gnt0, gnt1, rvalid0, rvalid1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "timeout");
  end

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [233:0] outs;
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    outs = {gnt0, gnt1, rvalid0, rvalid1, ram_writeEn, ram_adr, ram_writeData, rdata0, rdata1};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_state: outputs=%h, expected all zero", outs);
    end
    @(negedge clk) rst_n = 1'b1;
    mem[5] = 64'h55;
    req0 = 1'b1; we0 = 1'b1; adr0 = 16'd5; wdata0 = 64'h1234;
    @(negedge clk);
    n_tests++;
    if ({gnt0, ram_writeEn, ram_adr} !== {1'b1, 1'b1, 16'd5}) begin
      n_fail++;
      $display("FAIL reset_pre_write: gnt0=%0b we=%0b adr=%h, expected 1 1 0005", gnt0, ram_writeEn, ram_adr);
    end
    req0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    outs = {gnt0, gnt1, rvalid0, rvalid1, ram_writeEn, ram_adr, ram_writeData, rdata0, rdata1};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_access: outputs=%h, expected all zero", outs);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (mem[5] !== 64'h55) begin
      n_fail++;
      $display("FAIL reset_write_dropped: mem[5]=%h, expected %h", mem[5], 64'h55);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    mem[3] = 64'hDEAD_BEEF;
    exp_q.push_back('{port: 1'b0, data: 64'hDEAD_BEEF});
    req0 = 1'b1; we0 = 1'b0; adr0 = 16'd3;
    @(negedge clk);
    n_tests++;
    if ({gnt0, gnt1, ram_writeEn, ram_adr} !== {1'b1, 1'b0, 1'b0, 16'd3}) begin
      n_fail++;
      $display("FAIL read_gnt: gnt0=%0b gnt1=%0b we=%0b adr=%h, expected 1 0 0 0003", gnt0, gnt1, ram_writeEn, ram_adr);
    end
    req0 = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({rvalid0, rvalid1, gnt0, gnt1, rdata0} !== {4'b1000, 64'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL read_resp: rv0=%0b rv1=%0b g0=%0b g1=%0b rdata0=%h, expected 1 0 0 0 deadbeef",
               rvalid0, rvalid1, gnt0, gnt1, rdata0);
    end
    @(negedge clk);
    n_tests++;
    if ({rvalid0, rdata0} !== {1'b0, 64'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL read_hold: rvalid0=%0b rdata0=%h, expected 0 deadbeef", rvalid0, rdata0);
    end
  endtask

  task automatic test_write_read();
    req1 = 1'b1; we1 = 1'b1; adr1 = 16'd7; wdata1 = 64'd42;
    @(negedge clk);
    n_tests++;
    if ({gnt1, gnt0, ram_writeEn, ram_adr, ram_writeData} !== {3'b101, 16'd7, 64'd42}) begin
      n_fail++;
      $display("FAIL write_gnt: g1=%0b g0=%0b we=%0b adr=%h wd=%h, expected 1 0 1 0007 42",
               gnt1, gnt0, ram_writeEn, ram_adr, ram_writeData);
    end
    req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({rvalid1, ram_writeEn, mem[7]} !== {2'b00, 64'd42}) begin
      n_fail++;
      $display("FAIL write_commit: rvalid1=%0b we=%0b mem[7]=%h, expected 0 0 42", rvalid1, ram_writeEn, mem[7]);
    end
    exp_q.push_back('{port: 1'b1, data: 64'd42});
    req1 = 1'b1; adr1 = 16'd7;
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({rvalid1, rdata1, rdata0} !== {1'b1, 64'd42, 64'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL write_readback: rvalid1=%0b rdata1=%h rdata0=%h, expected 1 42 deadbeef", rvalid1, rdata1, rdata0);
    end
  endtask

  task automatic test_full_address();
    mem[255] = 64'hF00D_0000_CAFE;
    exp_q.push_back('{port: 1'b0, data: 64'hF00D_0000_CAFE});
    req0 = 1'b1; adr0 = 16'hFFFF;
    @(negedge clk);
    n_tests++;
    if ({gnt0, ram_adr} !== {1'b1, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL full_adr: gnt0=%0b ram_adr=%h, expected 1 ffff", gnt0, ram_adr);
    end
    req0 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie();
    bit port;
    logic [1:0] expg;
    pulse_reset();
    mem[10] = 64'hAAAA;
    mem[11] = 64'hBBBB;
    for (int unsigned i = 0; i < 4; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      port = 1'b0;
`else
      port = i[0];
`endif
      exp_q.push_back('{port: port, data: port ? 64'hBBBB : 64'hAAAA});
    end
    req0 = 1'b1; we0 = 1'b0; adr0 = 16'd10;
    req1 = 1'b1; we1 = 1'b0; adr1 = 16'd11;
    for (int unsigned k = 1; k <= 7; k++) begin
      @(negedge clk);
      expg = 2'b00;
      if (k[0]) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        expg = 2'b01;
`else
        expg = (((k - 1) / 2) % 2 == 1) ? 2'b10 : 2'b01;
`endif
      end
      n_tests++;
      if ({gnt1, gnt0} !== expg) begin
        n_fail++;
        $display("FAIL tie_order cycle %0d: {gnt1,gnt0}=%b, expected %b", k, {gnt1, gnt0}, expg);
      end
    end
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rerequest();
    logic [1:0] expg;
    mem[20] = 64'hC0C0;
    mem[21] = 64'hD0D0;
    exp_q.push_back('{port: 1'b0, data: 64'hC0C0});
    exp_q.push_back('{port: 1'b0, data: 64'hC0C0});
    req0 = 1'b1; we0 = 1'b0; adr0 = 16'd20;
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk);
      expg = k[0] ? 2'b01 : 2'b00;
      n_tests++;
      if ({gnt1, gnt0} !== expg) begin
        n_fail++;
        $display("FAIL rereq_alone cycle %0d: {gnt1,gnt0}=%b, expected %b", k, {gnt1, gnt0}, expg);
      end
    end
    idle_inputs();
    repeat (2) @(negedge clk);

    exp_q.push_back('{port: 1'b0, data: 64'hC0C0});
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_q.push_back('{port: 1'b0, data: 64'hC0C0});
    expg = 2'b01;
`else
    exp_q.push_back('{port: 1'b1, data: 64'hD0D0});
    expg = 2'b10;
`endif
    req0 = 1'b1; adr0 = 16'd20;
    @(negedge clk);
    n_tests++;
    if ({gnt1, gnt0} !== 2'b01) begin
      n_fail++;
      $display("FAIL rereq_first: {gnt1,gnt0}=%b, expected 01", {gnt1, gnt0});
    end
    req1 = 1'b1; we1 = 1'b0; adr1 = 16'd21;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({gnt1, gnt0} !== expg) begin
      n_fail++;
      $display("FAIL rereq_contend: {gnt1,gnt0}=%b, expected %b", {gnt1, gnt0}, expg);
    end
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int unsigned i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_full_address();
    test_tie();
    test_rerequest();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
